n1_prog_loader: RTL
===================

Name: n1_prog_loader

Overview:
Upstream program-load stage for the n1 core. It receives a program as a byte stream on the pins and assembles big-endian 16-bit words. It writes them sequentially into the core's instruction RAM, checks an XOR checksum, and asserts cpu_run only after a clean load. Downstream, the core fetches from address 0 once cpu_run rises.

Parameters:
RAM_WORDS, 128, depth of the instruction RAM in 16-bit words
ADDR_BITS, $clog2(RAM_WORDS), RAM word-address width (derived; do not override)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  synchronous one-cycle pulse; begins (or restarts) a load
byte_in  input  8  pin data byte; stable from 1 cycle before byte_stb rises until 3 cycles after
byte_stb  input  1  asynchronous pin strobe; each rising edge delivers one byte
mem_we  output  1  one-cycle RAM write strobe
mem_addr  output  ADDR_BITS  RAM word address for the write
mem_wdata  output  16  RAM write data, {high byte, low byte}
cpu_run  output  1  core release; high only in DONE
loading  output  1  high in COUNT, HI, LO, CHECK
load_err  output  1  high in ERROR
words_loaded  output  ADDR_BITS+1  number of words written in the current load

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs are 0, including mem_addr, mem_wdata and words_loaded. Synchronizer flops are 0. A reset mid-load aborts immediately. RAM contents are not touched.
- byte_stb path: 2-flop synchronizer, then a third flop for edge detect.
  - A byte is accepted on the cycle the synchronized rise is detected. This is 3 clk edges after the pin rises.
  - byte_in is captured in that same cycle.
  - Edges that arrive in IDLE, DONE or ERROR are discarded.
- Stream format: COUNT byte N, then N word pairs (HI byte, LO byte), then one CHK byte. CHK equals the XOR of all 2N data bytes; N is excluded from the checksum.
- State machine:
  - IDLE: start -> COUNT; clear words_loaded, address counter and checksum.
  - COUNT: accept byte N.
    - N == 0 or N > RAM_WORDS -> ERROR.
    - Otherwise latch N -> HI.
  - HI: accept byte; hold it in a register; checksum ^= byte -> LO.
  - LO: accept byte; checksum ^= byte.
    - Next cycle: mem_we = 1, mem_addr = address counter, mem_wdata = {hi, lo}.
    - Address counter and words_loaded increment in that same cycle.
    - If words_loaded + 1 == N -> CHECK, else -> HI.
  - CHECK: accept byte.
    - Match with checksum -> DONE.
    - Mismatch -> ERROR.
  - DONE: cpu_run = 1; stays until start or reset.
  - ERROR: load_err = 1; stays until start or reset.
- start in any state (including mid-load, DONE or ERROR) -> COUNT with counters cleared. cpu_run and load_err drop on the next edge.
- Simultaneous start and accepted byte: start wins and the byte is dropped.
- mem_we is a single-cycle pulse per word; it is never asserted outside the cycle after LO. Maximum one write per 2 accepted bytes.
- mem_addr and mem_wdata hold their last value when mem_we is low.
- Address counter cannot wrap, because N ≤ RAM_WORDS is enforced in COUNT.
- words_loaded is ADDR_BITS+1 wide so it reaches RAM_WORDS exactly.
- Failed loads leave partially written words in RAM (no rollback). cpu_run staying low is the only guard.
- Checksum and all arithmetic are unsigned and truncated to their declared widths.

Decomposition:
- Shared package n1_pkg holds:
  - loader state enum: IDLE, COUNT, HI, LO, CHECK, DONE, ERROR
  - RAM_WORDS default and word-width constant (16)
  - the XOR-checksum seed constant (8'h00)
- One sub-module, n1_strobe_sync: 2-flop synchronizer plus rising-edge detector with asynchronous active-low reset. It outputs a one-cycle stb_rise.

Test Plan:
- Reset then start, stream 02, 12 34, AB CD, CHK 0x40 -> two mem_we pulses: addr 0 data 0x1234, addr 1 data 0xABCD; words_loaded = 2; cpu_run = 1; load_err = 0.
- Same stream with CHK 0x41 -> both words written; ERROR state; load_err = 1; cpu_run = 0.
- COUNT byte 0x00, and separately COUNT byte 0x81 (129) -> ERROR immediately; no mem_we pulses.
- Load 128 words of 0x5A5A with CHK 0x00 -> last write at addr 127; words_loaded = 128; DONE.
- Pulse start after 3 bytes of a load, then send a clean 1-word stream 01, 00 07, CHK 07 -> single write addr 0 data 0x0007; cpu_run = 1.
- Assert rst_n low mid-LO phase -> all outputs 0 asynchronously; byte_stb edges ignored until the next start.

Source files
------------

// File: rtl/n1_pkg.sv
// rtl/n1_pkg.sv - shared types and constants for the n1 program loader
package n1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    CHECK,
    DONE,
    ERROR
  } load_state_t;

  localparam int         RAM_WORDS_DEFAULT = 128;
  localparam int         WORD_W            = 16;
  localparam logic [7:0] CHK_SEED          = 8'h00;

endpackage

// File: rtl/n1_strobe_sync.sv
// rtl/n1_strobe_sync.sv - two-flop synchronizer plus rising-edge detect for the pin strobe
module n1_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_async,
  output logic stb_rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= stb_async;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign stb_rise = sync2 & ~sync3;

endmodule

// File: rtl/n1_prog_loader.sv
// rtl/n1_prog_loader.sv - byte-stream program loader into the n1 instruction RAM with XOR check
module n1_prog_loader
  import n1_pkg::*;
#(
  parameter  int RAM_WORDS = RAM_WORDS_DEFAULT,
  localparam int ADDR_BITS = $clog2(RAM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_stb,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  output logic                 cpu_run,
  output logic                 loading,
  output logic                 load_err,
  output logic [ADDR_BITS:0]   words_loaded
);

  localparam int CW = ADDR_BITS + 1;

  load_state_t          state;
  logic                 stb_rise;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [ADDR_BITS:0]   n_words;
  logic [7:0]           hi_byte;
  logic [7:0]           csum;

  n1_strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb_async(byte_stb),
    .stb_rise (stb_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      loading      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      addr_cnt     <= '0;
      n_words      <= '0;
      hi_byte      <= 8'h00;
      csum         <= CHK_SEED;
    end else begin
      mem_we <= 1'b0;
      // start overrides everything, including a byte accepted in the same cycle
      if (start) begin
        state        <= COUNT;
        cpu_run      <= 1'b0;
        load_err     <= 1'b0;
        loading      <= 1'b1;
        words_loaded <= '0;
        addr_cnt     <= '0;
        csum         <= CHK_SEED;
      end else if (stb_rise) begin
        case (state)
          COUNT: begin
            if (byte_in == 8'd0 || 32'(byte_in) > RAM_WORDS) begin
              state    <= ERROR;
              loading  <= 1'b0;
              load_err <= 1'b1;
            end else begin
              n_words <= CW'(byte_in);
              state   <= HI;
            end
          end
          HI: begin
            hi_byte <= byte_in;
            csum    <= csum ^ byte_in;
            state   <= LO;
          end
          LO: begin
            csum         <= csum ^ byte_in;
            mem_we       <= 1'b1;
            mem_addr     <= addr_cnt;
            mem_wdata    <= {hi_byte, byte_in};
            addr_cnt     <= addr_cnt + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            state        <= (words_loaded + 1'b1 == n_words) ? CHECK : HI;
          end
          CHECK: begin
            loading <= 1'b0;
            if (byte_in == csum) begin
              state   <= DONE;
              cpu_run <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
